hazard_interlock: RTL and testbench

- Parametrised load-use interlock for the 5-stage MIPS pipeline; sits between the IF/ID and ID/EX registers.
- Detects a load in EX whose destination (rt) feeds the instruction in ID.
- Holds PC and IF/ID and injects bubbles into ID/EX for a configurable, memory-extendable number of cycles.
- Also handles branch flush and keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/hazard_interlock_if.sv | 28 ++
 rtl/hazard_interlock.sv | 102 ++++++++++
 tb/tb_hazard_interlock.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_interlock_if.sv
// Signal bundle between the IF/ID, ID/EX control logic and the load-use interlock.
// The pipeline side uses the master modport, the interlock uses the slave modport.
interface hazard_interlock_if #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
);
   logic [31:0]      instruction;
   logic             id_valid;
   logic [REG_W-1:0] rt_ex;
   logic             mem_to_reg_ex;
   logic             mem_busy;
   logic             branch_flush;
   logic             cnt_clr;
   logic             stop;
   logic             bubble;
   logic             flush_if_id;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output instruction, id_valid, rt_ex, mem_to_reg_ex, mem_busy, branch_flush, cnt_clr,
      input  stop, bubble, flush_if_id, stall_count
   );

   modport slave (
      input  instruction, id_valid, rt_ex, mem_to_reg_ex, mem_busy, branch_flush, cnt_clr,
      output stop, bubble, flush_if_id, stall_count
   );
endinterface

// File: rtl/hazard_interlock.sv
// Load-use interlock for the 5-stage MIPS pipeline. A load in EX whose destination
// feeds the instruction in ID freezes PC/IF-ID and bubbles ID/EX for LOAD_LAT cycles,
// stretched while data memory is busy. A resolved branch squashes IF/ID and cancels
// any stall. A saturating counter records how many cycles the pipe was held.
module hazard_interlock #(
   parameter int REG_W    = 5,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16,
   parameter int CHECK_RT = 1,
   parameter int SKIP_R0  = 1
) (
   input  logic           clk,
   input  logic           reset,
   hazard_interlock_if.slave bus
);

   typedef enum logic [0:0] {IDLE, STALL} state_t;

   state_t           r_state;
   logic [3:0]       r_cnt;
   logic [CNT_W-1:0] r_stall_count;

   logic [REG_W-1:0] w_rs;
   logic [REG_W-1:0] w_rt;
   logic             w_src_match;
   logic             w_hit;
   logic             w_stop;
   logic             w_unused;

   // Opcode and immediate/funct bits play no part in hazard detection.
   assign w_unused = ^{bus.instruction[31:26], bus.instruction[15:0]};

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign w_rs = REG_W'(bus.instruction[25:21]);
   assign w_rt = REG_W'(bus.instruction[20:16]);

   // Load-use hit: EX load destination matches a source of the ID instruction.
   always_comb begin
      w_src_match = (bus.rt_ex == w_rs) || ((CHECK_RT != 0) && (bus.rt_ex == w_rt));
      w_hit       = bus.mem_to_reg_ex && bus.id_valid && w_src_match &&
                    !((SKIP_R0 != 0) && (bus.rt_ex == '0));
   end

   // Stall request: zero-latency on a fresh hit, forced while in STALL, killed by a flush.
   always_comb begin
      w_stop = 1'b0;
      if (!bus.branch_flush) begin
         w_stop = (r_state == STALL) || w_hit;
      end
   end

   assign bus.stop        = w_stop;
   assign bus.bubble      = w_stop;
   assign bus.flush_if_id = bus.branch_flush;
   assign bus.stall_count = r_stall_count;

   // Stall sequencing: cnt counts the remaining base cycles, the last one holds on mem_busy.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
      end else if (bus.branch_flush) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_hit) begin
                  r_cnt   <= 4'(LOAD_LAT - 1);
                  r_state <= (LOAD_LAT > 1) ? STALL : IDLE;
               end
            end
            STALL: begin
               if (r_cnt > 4'd1) begin
                  r_cnt <= r_cnt - 4'd1;
               end else if (!bus.mem_busy) begin
                  r_cnt   <= 4'd0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= 4'd0;
            end
         endcase
      end
   end

   // Performance counter of held cycles; clear wins over increment.
   always_ff @(posedge clk) begin
      if (reset || bus.cnt_clr) begin
         r_stall_count <= '0;
      end else if (w_stop) begin
         r_stall_count <= sat_inc(r_stall_count);
      end
   end

endmodule

// File: tb/tb_hazard_interlock.sv
// Bench for hazard_interlock: three configurations share one stimulus stream and are
// compared against a cycle-level model built from the interlock rules.
module tb_hazard_interlock;

   logic        clk;
   logic        reset;
   logic [31:0] instruction;
   logic        id_valid;
   logic [4:0]  rt_ex;
   logic        mem_to_reg_ex;
   logic        mem_busy;
   logic        branch_flush;
   logic        cnt_clr;

   int checks = 0;
   int errors = 0;

   // Configurations: 0 = defaults, 1 = LAT3/CNT4/no rt/no r0 skip, 2 = LAT3 with defaults otherwise
   int CFG_LAT [3] = '{1, 3, 3};
   int CFG_CW  [3] = '{16, 4, 16};
   bit CFG_CRT [3] = '{1'b1, 1'b0, 1'b1};
   bit CFG_SR0 [3] = '{1'b1, 1'b0, 1'b1};

   int     m_left [3];
   longint m_cnt  [3];

   logic        o_stop  [3];
   logic        o_bub   [3];
   logic        o_flush [3];
   logic [15:0] o_cnt   [3];

   hazard_interlock_if #(.REG_W(5), .CNT_W(16)) ifA ();
   hazard_interlock_if #(.REG_W(5), .CNT_W(4))  ifB ();
   hazard_interlock_if #(.REG_W(5), .CNT_W(16)) ifC ();

   assign ifA.instruction = instruction;   assign ifB.instruction = instruction;   assign ifC.instruction = instruction;
   assign ifA.id_valid = id_valid;         assign ifB.id_valid = id_valid;         assign ifC.id_valid = id_valid;
   assign ifA.rt_ex = rt_ex;               assign ifB.rt_ex = rt_ex;               assign ifC.rt_ex = rt_ex;
   assign ifA.mem_to_reg_ex = mem_to_reg_ex; assign ifB.mem_to_reg_ex = mem_to_reg_ex; assign ifC.mem_to_reg_ex = mem_to_reg_ex;
   assign ifA.mem_busy = mem_busy;         assign ifB.mem_busy = mem_busy;         assign ifC.mem_busy = mem_busy;
   assign ifA.branch_flush = branch_flush; assign ifB.branch_flush = branch_flush; assign ifC.branch_flush = branch_flush;
   assign ifA.cnt_clr = cnt_clr;           assign ifB.cnt_clr = cnt_clr;           assign ifC.cnt_clr = cnt_clr;

   assign o_stop[0] = ifA.stop;  assign o_stop[1] = ifB.stop;  assign o_stop[2] = ifC.stop;
   assign o_bub[0]  = ifA.bubble; assign o_bub[1] = ifB.bubble; assign o_bub[2] = ifC.bubble;
   assign o_flush[0] = ifA.flush_if_id; assign o_flush[1] = ifB.flush_if_id; assign o_flush[2] = ifC.flush_if_id;
   assign o_cnt[0] = ifA.stall_count;
   assign o_cnt[1] = {12'd0, ifB.stall_count};
   assign o_cnt[2] = ifC.stall_count;

   hazard_interlock #(.REG_W(5), .LOAD_LAT(1), .CNT_W(16), .CHECK_RT(1), .SKIP_R0(1))
      uA (.clk(clk), .reset(reset), .bus(ifA));
   hazard_interlock #(.REG_W(5), .LOAD_LAT(3), .CNT_W(4), .CHECK_RT(0), .SKIP_R0(0))
      uB (.clk(clk), .reset(reset), .bus(ifB));
   hazard_interlock #(.REG_W(5), .LOAD_LAT(3), .CNT_W(16), .CHECK_RT(1), .SKIP_R0(1))
      uC (.clk(clk), .reset(reset), .bus(ifC));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] make_instr(input int rs, input int rt);
      logic [4:0] a;
      logic [4:0] b;
      a = rs[4:0];
      b = rt[4:0];
      return {6'h23, a, b, 16'h0010};
   endfunction

   // Reference: hazard from the register fields with plain arithmetic.
   function automatic bit m_hit(input int k);
      int rs, rt, d;
      rs = (instruction >> 21) & 31;
      rt = (instruction >> 16) & 31;
      d  = rt_ex;
      if (!(mem_to_reg_ex && id_valid)) return 0;
      if (CFG_SR0[k] && d == 0) return 0;
      return (d == rs) || (CFG_CRT[k] && d == rt);
   endfunction

   // Reference: pipeline held while forced cycles remain or a fresh hit appears.
   function automatic bit m_stop(input int k);
      if (branch_flush) return 0;
      if (m_left[k] > 0) return 1;
      return m_hit(k);
   endfunction

   // One clock edge; the model advances with the inputs present at that edge.
   task automatic tick();
      bit s [3];
      bit h [3];
      longint mx;
      for (int k = 0; k < 3; k++) begin
         s[k] = m_stop(k);
         h[k] = m_hit(k);
      end
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         mx = (longint'(1) << CFG_CW[k]) - 1;
         if (reset || branch_flush) m_left[k] = 0;
         else if (m_left[k] > 0) begin
            if (!(m_left[k] == 1 && mem_busy)) m_left[k] = m_left[k] - 1;
         end else if (h[k]) m_left[k] = CFG_LAT[k] - 1;
         if (reset || cnt_clr) m_cnt[k] = 0;
         else if (s[k]) m_cnt[k] = (m_cnt[k] + 1 > mx) ? mx : m_cnt[k] + 1;
      end
      #1;
   endtask

   task automatic idle_inputs();
      instruction   = make_instr(31, 30);
      id_valid      = 1'b0;
      rt_ex         = 5'd0;
      mem_to_reg_ex = 1'b0;
      mem_busy      = 1'b0;
      branch_flush  = 1'b0;
      cnt_clr       = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic set_hit(input int d, input int rs, input int rt);
      rt_ex         = d[4:0];
      instruction   = make_instr(rs, rt);
      id_valid      = 1'b1;
      mem_to_reg_ex = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (o_stop[k] !== 1'b0 || o_bub[k] !== 1'b0 || o_flush[k] !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs cfg%0d got stop=%b bubble=%b flush=%b required 0 0 0",
                     k, o_stop[k], o_bub[k], o_flush[k]);
         end
         checks++;
         if (o_cnt[k] !== 16'd0) begin
            errors++;
            $display("FAIL reset_count cfg%0d got %0d required 0", k, o_cnt[k]);
         end
      end
   endtask

   task automatic test_load_use();
      do_reset();
      set_hit(4, 4, 9);
      #1;
      checks++;
      if (o_stop[0] !== 1'b1 || o_bub[0] !== 1'b1) begin
         errors++;
         $display("FAIL load_use_same_cycle got stop=%b bubble=%b required 1 1", o_stop[0], o_bub[0]);
      end
      tick();
      mem_to_reg_ex = 1'b0;
      #1;
      checks++;
      if (o_stop[0] !== 1'b0) begin
         errors++;
         $display("FAIL load_use_release got stop=%b required 0", o_stop[0]);
      end
      checks++;
      if (o_cnt[0] !== 16'd1) begin
         errors++;
         $display("FAIL load_use_count got %0d required 1", o_cnt[0]);
      end
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_check_rt();
      do_reset();
      set_hit(3, 7, 3);
      #1;
      checks++;
      if (o_stop[0] !== 1'b1) begin
         errors++;
         $display("FAIL rt_match_checked got stop=%b required 1", o_stop[0]);
      end
      checks++;
      if (o_stop[1] !== 1'b0) begin
         errors++;
         $display("FAIL rt_match_unchecked got stop=%b required 0", o_stop[1]);
      end
      set_hit(2, 3, 3);
      #1;
      checks++;
      if (o_stop[0] !== 1'b0 || o_stop[2] !== 1'b0) begin
         errors++;
         $display("FAIL no_match got stop=%b/%b required 0/0", o_stop[0], o_stop[2]);
      end
      mem_to_reg_ex = 1'b0;
      tick();
   endtask

   task automatic test_skip_r0();
      do_reset();
      set_hit(0, 0, 0);
      #1;
      checks++;
      if (o_stop[0] !== 1'b0) begin
         errors++;
         $display("FAIL r0_skipped got stop=%b required 0", o_stop[0]);
      end
      checks++;
      if (o_stop[1] !== 1'b1) begin
         errors++;
         $display("FAIL r0_not_skipped got stop=%b required 1", o_stop[1]);
      end
      mem_to_reg_ex = 1'b0;
      tick();
   endtask

   task automatic test_load_lat();
      int n;
      for (int run = 0; run < 2; run++) begin
         do_reset();
         n = 0;
         for (int i = 0; i < 9; i++) begin
            if (i == 0) set_hit(4, 4, 9);
            else mem_to_reg_ex = 1'b0;
            mem_busy = (run == 1) && (i == 2 || i == 3);
            #1;
            if (o_stop[2] === 1'b1) n++;
            tick();
         end
         mem_busy = 1'b0;
         checks++;
         if (n != 3 + 2 * run) begin
            errors++;
            $display("FAIL load_lat_len run%0d got %0d cycles required %0d", run, n, 3 + 2 * run);
         end
         checks++;
         if (o_cnt[2] !== 16'(3 + 2 * run)) begin
            errors++;
            $display("FAIL load_lat_count run%0d got %0d required %0d", run, o_cnt[2], 3 + 2 * run);
         end
      end
   endtask

   task automatic test_branch_flush();
      do_reset();
      set_hit(4, 4, 9);
      #1;
      checks++;
      if (o_stop[2] !== 1'b1) begin
         errors++;
         $display("FAIL flush_prestall got stop=%b required 1", o_stop[2]);
      end
      tick();
      mem_to_reg_ex = 1'b0;
      branch_flush  = 1'b1;
      #1;
      checks++;
      if (o_flush[2] !== 1'b1 || o_stop[2] !== 1'b0 || o_bub[2] !== 1'b0) begin
         errors++;
         $display("FAIL flush_midstall got flush=%b stop=%b bubble=%b required 1 0 0",
                  o_flush[2], o_stop[2], o_bub[2]);
      end
      tick();
      branch_flush = 1'b0;
      #1;
      checks++;
      if (o_stop[2] !== 1'b0 || o_flush[2] !== 1'b0) begin
         errors++;
         $display("FAIL flush_after got stop=%b flush=%b required 0 0", o_stop[2], o_flush[2]);
      end
      tick();
      set_hit(4, 4, 9);
      branch_flush = 1'b1;
      #1;
      checks++;
      if (o_stop[2] !== 1'b0 || o_stop[0] !== 1'b0 || o_flush[2] !== 1'b1) begin
         errors++;
         $display("FAIL flush_with_hit got stop=%b/%b flush=%b required 0/0 1",
                  o_stop[2], o_stop[0], o_flush[2]);
      end
      tick();
      mem_to_reg_ex = 1'b0;
      branch_flush  = 1'b0;
      #1;
      checks++;
      if (o_stop[2] !== 1'b0) begin
         errors++;
         $display("FAIL flush_hit_ignored got stop=%b required 0", o_stop[2]);
      end
      tick();
   endtask

   task automatic test_saturation();
      do_reset();
      set_hit(4, 4, 9);
      for (int i = 0; i < 20; i++) tick();
      checks++;
      if (o_cnt[1] !== 16'd15) begin
         errors++;
         $display("FAIL count_saturate got %0d required 15", o_cnt[1]);
      end
      checks++;
      if (o_cnt[0] !== 16'd20) begin
         errors++;
         $display("FAIL count_wide got %0d required 20", o_cnt[0]);
      end
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      checks++;
      if (o_cnt[1] !== 16'd0 || o_cnt[0] !== 16'd0) begin
         errors++;
         $display("FAIL count_clear got %0d/%0d required 0/0", o_cnt[1], o_cnt[0]);
      end
      mem_to_reg_ex = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      set_hit(4, 4, 9);
      tick();
      mem_to_reg_ex = 1'b0;
      #1;
      checks++;
      if (o_stop[2] !== 1'b1) begin
         errors++;
         $display("FAIL midstall_entry got stop=%b required 1", o_stop[2]);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (o_stop[2] !== 1'b0 || o_cnt[2] !== 16'd0) begin
         errors++;
         $display("FAIL midstall_reset got stop=%b count=%0d required 0 0", o_stop[2], o_cnt[2]);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         rt_ex         = 5'($urandom_range(0, 3));
         instruction   = make_instr($urandom_range(0, 3), $urandom_range(0, 3));
         mem_to_reg_ex = ($urandom_range(0, 2) != 0);
         id_valid      = ($urandom_range(0, 3) != 0);
         mem_busy      = $urandom_range(0, 1) == 1;
         branch_flush  = ($urandom_range(0, 9) == 0);
         cnt_clr       = ($urandom_range(0, 24) == 0);
         reset         = ($urandom_range(0, 59) == 0);
         #1;
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (o_stop[k] !== m_stop(k) || o_bub[k] !== m_stop(k)) begin
               errors++;
               $display("FAIL rand_stop cfg%0d cyc%0d got stop=%b bubble=%b required %b",
                        k, c, o_stop[k], o_bub[k], m_stop(k));
            end
            checks++;
            if (o_flush[k] !== branch_flush) begin
               errors++;
               $display("FAIL rand_flush cfg%0d cyc%0d got %b required %b", k, c, o_flush[k], branch_flush);
            end
            checks++;
            if (longint'(o_cnt[k]) != m_cnt[k]) begin
               errors++;
               $display("FAIL rand_count cfg%0d cyc%0d got %0d required %0d", k, c, o_cnt[k], m_cnt[k]);
            end
         end
         tick();
      end
      reset = 1'b0;
      idle_inputs();
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         m_left[k] = 0;
         m_cnt[k]  = 0;
      end
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_load_use();
      test_check_rt();
      test_skip_r0();
      test_load_lat();
      test_branch_flush();
      test_saturation();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
